// File: rtl/pixel_fetch_pkg.sv
// Shared definitions for the pixel fetch controller.
//   fetch_state_t          : FSM state encoding (IDLE, ISSUE, RELEASE, DONE)
//   DEFAULT_FALLBACK_COLOR : color pushed when a CPU request times out
//   POS_W                  : width of each pixel coordinate
//   pack_pos()             : packs (x, y) into the 32-bit {y, x} position word
package pixel_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } fetch_state_t;

  localparam logic [23:0] DEFAULT_FALLBACK_COLOR = 24'h000000;
  localparam int          POS_W                  = 16;

  function automatic logic [31:0] pack_pos(input logic [POS_W-1:0] x,
                                           input logic [POS_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead prefetch FIFO holding {color[23:0], eol, eof} entries.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/occupancy only)
//   flush       : empties the FIFO this cycle; wins over push and pop
//   push, push_data : write one entry (caller never pushes while full)
//   pop         : consume the head entry when out_valid is set
//   out_valid   : head entry present
//   out_data    : head entry, forced to zero while empty
//   full        : DEPTH entries held
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop_ok    = pop && out_valid;
  // Zero while empty so storage never needs a reset.
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Pixel fetch controller: walks the frame raster, requests each pixel color
// from a CPU over a four-phase PIO handshake and buffers the colors, tagged
// with end-of-line / end-of-frame flags, in a show-ahead prefetch FIFO.
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   frame_start            : restart fetching at pixel (0,0), flushing mid-frame
//   pix_pos, pix_req       : position {y,x} and request towards the CPU
//   pix_color, pix_ack     : color and acknowledge from the CPU
//   out_valid/out_ready    : FIFO head handshake towards scanout
//   out_color/eol/eof      : FIFO head contents
//   timeout_cnt            : saturating count of timed-out requests
// Optional feature: define PIXEL_FETCH_TIMEOUT_EN to give up on a request
// after TIMEOUT cycles and push FALLBACK_COLOR instead; otherwise the
// controller waits indefinitely and timeout_cnt reads zero.
import pixel_fetch_pkg::*;

module pixel_fetch_ctrl #(
  parameter int          H_RES          = 640,
  parameter int          V_RES          = 480,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          TIMEOUT        = 255,
  parameter logic [23:0] FALLBACK_COLOR = DEFAULT_FALLBACK_COLOR
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        frame_start,
  output logic [31:0] pix_pos,
  output logic        pix_req,
  input  logic [23:0] pix_color,
  input  logic        pix_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_color,
  output logic        out_eol,
  output logic        out_eof,
  output logic [15:0] timeout_cnt
);

  localparam logic [POS_W-1:0] X_LAST = POS_W'(H_RES - 1);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_RES - 1);

  fetch_state_t     state_q, state_d;
  logic [POS_W-1:0] x_q, y_q;
  logic             restart_q;
  logic             mid_frame;
  logic             is_eol, is_eof;
  logic             accept;
  logic             timeout_fire;
  logic             fifo_full;
  logic             fifo_flush;
  logic             pop;
  logic             push_vld_p0;
  logic [25:0]      push_data_p0;
  logic [25:0]      head_data;

  assign mid_frame = (state_q == ST_ISSUE) || (state_q == ST_RELEASE);
  assign is_eol    = (x_q == X_LAST);
  assign is_eof    = is_eol && (y_q == Y_LAST);
  assign accept    = pix_req && pix_ack;

  // ---- stage p0: CPU color capture into the FIFO ----
  // A frame_start in the capture cycle discards the color.
  assign push_vld_p0  = (accept || timeout_fire) && !frame_start;
  assign push_data_p0 = {(timeout_fire ? FALLBACK_COLOR : pix_color), is_eol, is_eof};
  assign fifo_flush   = frame_start && mid_frame;
  assign pop          = out_valid && out_ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (26)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .flush     (fifo_flush),
    .push      (push_vld_p0),
    .push_data (push_data_p0),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (head_data),
    .full      (fifo_full)
  );

  assign {out_color, out_eol, out_eof} = head_data;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (frame_start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (frame_start || accept || timeout_fire) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A restart lands back in ISSUE at (0,0) rather than DONE.
        if (!frame_start && !pix_ack) begin
          state_d = (is_eof && !restart_q) ? ST_DONE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_req = (state_q == ST_ISSUE) && !fifo_full;
    pix_pos = pack_pos(x_q, y_q);
  end

  // Position advances when RELEASE completes; restart_q marks a release
  // that belongs to a dropped request and must not advance.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      restart_q <= 1'b0;
    end else if (frame_start) begin
      x_q       <= '0;
      y_q       <= '0;
      restart_q <= mid_frame;
    end else if ((state_q == ST_RELEASE) && !pix_ack) begin
      if (restart_q) begin
        restart_q <= 1'b0;
      end else if (!is_eof) begin
        if (is_eol) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

`ifdef PIXEL_FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q;
  logic [15:0]       tcnt_q;

  assign timeout_fire = pix_req && !pix_ack && (wait_q == WAIT_W'(TIMEOUT - 1));
  assign timeout_cnt  = tcnt_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wait_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (frame_start || !pix_req || pix_ack || timeout_fire) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + 1'b1;
      end
      if (timeout_fire && !frame_start && (tcnt_q != 16'hFFFF)) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_fire       = 1'b0;
  assign timeout_cnt        = '0;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

endmodule
